// File: rtl/icosoc_mod_audio_fifo.sv
// ---------------------------------------------------------------------------
// icosoc_mod_audio_fifo
//   Multi-channel delta-sigma audio output peripheral on the icosoc ctrl bus.
//   The CPU pushes sample frames into a FIFO. A programmable sample-rate
//   timer pops one frame per period into per-channel hold registers. Each
//   channel then drives a first-order delta-sigma modulator with a 1-bit
//   output.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   ctrl_wr    byte write strobes; any bit set = write request
//   ctrl_rd    read request
//   ctrl_addr  register byte address (0x0 DATA, 0x4 STATUS, 0x8 DIVIDER, 0xC CTRL)
//   ctrl_wdat  write data
//   ctrl_rdat  read data, valid while ctrl_done=1
//   ctrl_done  one-cycle access acknowledge
//   pdm_out    modulator outputs, bit i = channel i
// ---------------------------------------------------------------------------
module icosoc_mod_audio_fifo #(
    parameter int CLOCK_FREQ_HZ  = 20000000,
    parameter int SAMPLE_RATE_HZ = 8000,
    parameter int CHANNELS       = 2,
    parameter int SAMPLE_WIDTH   = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [3:0]          ctrl_wr,
    input  logic                ctrl_rd,
    input  logic [15:0]         ctrl_addr,
    input  logic [31:0]         ctrl_wdat,
    output logic [31:0]         ctrl_rdat,
    output logic                ctrl_done,
    output logic [CHANNELS-1:0] pdm_out
);

    localparam int SW = SAMPLE_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = CHANNELS * SW;
    localparam logic [15:0] DIV_RESET = 16'(CLOCK_FREQ_HZ / SAMPLE_RATE_HZ - 1);

    localparam logic [15:0] ADDR_DATA    = 16'h0000;
    localparam logic [15:0] ADDR_STATUS  = 16'h0004;
    localparam logic [15:0] ADDR_DIVIDER = 16'h0008;
    localparam logic [15:0] ADDR_CTRL    = 16'h000C;

    // Architectural state
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          enable, signed_mode;
    logic          underrun, overflow;
    logic [15:0]   divider, timer;
    logic [SW-1:0] held   [CHANNELS];
    logic [SW:0]   acc    [CHANNELS];
    logic [SW-1:0] mod_in [CHANNELS];

    // Upper data bits beyond the sample width carry no information
    logic unused_wdat;
    assign unused_wdat = ^ctrl_wdat;

    // Bus decode: a request is only accepted while no acknowledge is pending
    logic wr_req, rd_req;
    assign wr_req = (|ctrl_wr) && !ctrl_done;
    assign rd_req = ctrl_rd && !ctrl_done;

    logic push, status_we, div_we, ctl_we, flush;
    assign push      = wr_req && (ctrl_addr == ADDR_DATA);
    assign status_we = wr_req && (ctrl_addr == ADDR_STATUS);
    assign div_we    = wr_req && (ctrl_addr == ADDR_DIVIDER);
    assign ctl_we    = wr_req && (ctrl_addr == ADDR_CTRL);
    assign flush     = ctl_we && ctrl_wdat[2];

    logic empty, full, push_ok, tick, pop, underrun_set;
    assign empty        = (level == '0);
    assign full         = (level == (AW+1)'(FIFO_DEPTH));
    assign push_ok      = push && !full;
    assign tick         = enable && (timer == 16'd0);
    // A flush on the tick edge wins: no pop and no underrun for that tick
    assign pop          = tick && !flush && !empty;
    assign underrun_set = tick && !flush && empty;

    // Frame packing: channel c lives in the 16-bit lane c of the write data
    logic [FW-1:0] frame;
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        frame = '0;
        for (int c = 0; c < CHANNELS; c++)
            frame[c*SW +: SW] = ctrl_wdat[16*c +: SW];
    end

    // SIGNED flips the MSB: two's complement -> offset binary
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            mod_in[c]       = held[c];
            mod_in[c][SW-1] = held[c][SW-1] ^ signed_mode;
        end
    end

    logic [31:0] rd_val;
    always_comb begin
        rd_val = '0;
        case (ctrl_addr)
            ADDR_STATUS: begin
                rd_val[AW:0] = level;
                rd_val[8]    = empty;
                rd_val[9]    = full;
                rd_val[10]   = underrun;
                rd_val[11]   = overflow;
            end
            ADDR_DIVIDER: rd_val[15:0] = divider;
            ADDR_CTRL:    rd_val[1:0]  = {signed_mode, enable};
            default:      rd_val = '0;
        endcase
    end

    // Bus acknowledge and read data
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_done <= 1'b0;
            ctrl_rdat <= '0;
        end else begin
            ctrl_done <= wr_req || rd_req;
            ctrl_rdat <= rd_req ? rd_val : '0;
        end
    end

    // Control registers, timer and flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable      <= 1'b0;
            signed_mode <= 1'b0;
            divider     <= DIV_RESET;
            timer       <= DIV_RESET;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (ctl_we) begin
                enable      <= ctrl_wdat[0];
                signed_mode <= ctrl_wdat[1];
            end
            if (div_we)
                divider <= ctrl_wdat[15:0];

            if (div_we)               timer <= ctrl_wdat[15:0];
            else if (!enable || tick) timer <= divider;
            else                      timer <= timer - 16'd1;

            if (push && full)                     overflow <= 1'b1;
            else if (status_we && ctrl_wdat[11])  overflow <= 1'b0;
            if (underrun_set)                     underrun <= 1'b1;
            else if (status_we && ctrl_wdat[10])  underrun <= 1'b0;
        end
    end

    // FIFO pointers and level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; the level/pointers alone define
    // which entries are valid, so clearing the array would only add logic
    // and prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= frame;
    end

    // Held samples and delta-sigma modulators
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pdm_out <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                held[c] <= '0;
                acc[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (pop)
                    held[c] <= mem[rd_ptr][c*SW +: SW];
                if (!enable) begin
                    acc[c]     <= '0;
                    pdm_out[c] <= 1'b0;
                end else begin
                    // The carry out of the previous sum is the output bit
                    acc[c]     <= {1'b0, acc[c][SW-1:0]} + {1'b0, mod_in[c]};
                    pdm_out[c] <= acc[c][SW];
                end
            end
        end
    end

endmodule

// File: tb/tb_icosoc_mod_audio_fifo.sv
// ---------------------------------------------------------------------------
// tb_icosoc_mod_audio_fifo
//   Directed self-checking bench for icosoc_mod_audio_fifo with default
//   parameters (20 MHz, 8 kHz, 2 channels, 8-bit samples, 16-frame FIFO).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_icosoc_mod_audio_fifo;

    localparam logic [15:0] A_DATA    = 16'h0000;
    localparam logic [15:0] A_STATUS  = 16'h0004;
    localparam logic [15:0] A_DIVIDER = 16'h0008;
    localparam logic [15:0] A_CTRL    = 16'h000C;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  ctrl_wr;
    logic        ctrl_rd;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    logic [1:0]  pdm_out;

    int n_checks = 0;
    int n_pass   = 0;

    icosoc_mod_audio_fifo dut (
        .clk       (clk),
        .resetn    (resetn),
        .ctrl_wr   (ctrl_wr),
        .ctrl_rd   (ctrl_rd),
        .ctrl_addr (ctrl_addr),
        .ctrl_wdat (ctrl_wdat),
        .ctrl_rdat (ctrl_rdat),
        .ctrl_done (ctrl_done),
        .pdm_out   (pdm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus tasks are entered and left on a falling edge with ctrl_done low.
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        ctrl_wr   = 4'hF;
        ctrl_addr = addr;
        ctrl_wdat = data;
        @(negedge clk);
        ctrl_wr   = 4'h0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        ctrl_rd   = 1'b1;
        ctrl_addr = addr;
        @(negedge clk);
        ctrl_rd   = 1'b0;
        data      = ctrl_rdat;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic count_pdm(input int cycles, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            c0 += int'(pdm_out[0]);
            c1 += int'(pdm_out[1]);
        end
    endtask

    initial begin
        int c0, c1;
        resetn    = 1'b0;
        ctrl_wr   = 4'h0;
        ctrl_rd   = 1'b0;
        ctrl_addr = 16'h0;
        ctrl_wdat = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, ctrl_done}, 32'd0);
        check("rst_rdat", ctrl_rdat, 32'd0);
        check("rst_pdm",  {30'd0, pdm_out}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        read_check("rst_status",  A_STATUS,  32'h100);
        read_check("rst_divider", A_DIVIDER, 32'd2499);
        read_check("rst_ctrl",    A_CTRL,    32'h0);
        read_check("unmapped",    16'h0010,  32'h0);

        // Underrun: empty FIFO, DIVIDER=9, first tick after 10 clocks
        bus_write(A_DIVIDER, 32'd9);
        bus_write(A_CTRL, 32'h1);
        repeat (8) @(negedge clk);
        read_check("underrun_before", A_STATUS, 32'h100);
        read_check("underrun_after",  A_STATUS, 32'h500);
        count_pdm(40, c0, c1);
        check("underrun_pdm0", c0, 0);
        check("underrun_pdm1", c1, 0);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h400);
        read_check("underrun_clear", A_STATUS, 32'h100);

        // Overflow: 17 pushes with ENABLE=0
        for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'(i));
        read_check("full_status", A_STATUS, 32'hA10);
        bus_write(A_STATUS, 32'h0);
        read_check("w0_keeps_flags", A_STATUS, 32'hA10);
        bus_write(A_STATUS, 32'h800);
        read_check("overflow_clear", A_STATUS, 32'h210);
        bus_write(A_CTRL, 32'h4);
        read_check("flush_idle", A_STATUS, 32'h100);
        read_check("flush_ctrl", A_CTRL, 32'h0);

        // Basic playback: DIVIDER=3, ch0=0x40 (1/4), ch1=0x20 (1/8)
        bus_write(A_DIVIDER, 32'd3);
        read_check("divider_rb", A_DIVIDER, 32'd3);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_DATA, 32'h0020_0040);
        read_check("level_one",  A_STATUS, 32'h001);
        read_check("level_zero", A_STATUS, 32'h100);
        repeat (16) @(negedge clk);
        count_pdm(64, c0, c1);
        check("duty_ch0_quarter", c0, 16);
        check("duty_ch1_eighth",  c1, 8);
        bus_write(A_CTRL, 32'h0);
        check("disable_pdm", {30'd0, pdm_out}, 32'd0);
        bus_write(A_STATUS, 32'hC00);

        // Signed mode
        bus_write(A_CTRL, 32'h3);
        read_check("signed_ctrl", A_CTRL, 32'h3);
        bus_write(A_DATA, 32'h0000_0080);
        repeat (16) @(negedge clk);
        count_pdm(64, c0, c1);
        check("signed_0x80_ch0", c0, 0);
        bus_write(A_DATA, 32'h0000_007F);
        repeat (16) @(negedge clk);
        count_pdm(256, c0, c1);
        check("signed_0x7f_ch0", c0, 255);
        check("signed_zero_ch1", c1, 128);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'hC00);

        // Flush coincident with a tick: DIVIDER=1, tick lands on the flush edge
        bus_write(A_DIVIDER, 32'd1);
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'(i + 1));
        read_check("level_five", A_STATUS, 32'h005);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h5);
        read_check("flush_tick_status", A_STATUS, 32'h100);
        read_check("flush_selfclear", A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h0);

        // Mid-stream asynchronous reset with an acknowledge pending
        bus_write(A_DIVIDER, 32'd3);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_DATA, 32'h00C0_00C0);
        repeat (16) @(negedge clk);
        count_pdm(64, c0, c1);
        check("stream_ch0", c0, 48);
        ctrl_rd   = 1'b1;
        ctrl_addr = A_STATUS;
        @(posedge clk);
        #1;
        check("ack_pending", {31'd0, ctrl_done}, 32'd1);
        resetn = 1'b0;
        #1;
        check("async_done", {31'd0, ctrl_done}, 32'd0);
        check("async_pdm",  {30'd0, pdm_out}, 32'd0);
        ctrl_rd = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        read_check("post_rst_status",  A_STATUS,  32'h100);
        read_check("post_rst_divider", A_DIVIDER, 32'd2499);
        read_check("post_rst_ctrl",    A_CTRL,    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
